// File: rtl/gpio_seq_pkg.sv
// Shared constants and types for the GPIO command sequencer.
package gpio_seq_pkg;

  localparam logic [1:0] OP_WR_OPT = 2'd0;
  localparam logic [1:0] OP_WR_OEC = 2'd1;
  localparam logic [1:0] OP_DELAY  = 2'd2;
  localparam logic [1:0] OP_POLL   = 2'd3;

  localparam logic [7:0] SEQ_CTRL = 8'h00;
  localparam logic [7:0] SEQ_STAT = 8'h04;
  localparam logic [7:0] SEQ_ARG  = 8'h08;
  localparam logic [7:0] SEQ_MASK = 8'h0C;
  localparam logic [7:0] SEQ_CMD  = 8'h10;

  localparam logic [7:0] GPIO_DIN = 8'h00;
  localparam logic [7:0] GPIO_OPT = 8'h04;
  localparam logic [7:0] GPIO_OEC = 8'h08;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WRITE,
    ST_DELAY,
    ST_POLL_RD,
    ST_POLL_CHK
  } state_t;

  typedef struct packed {
    logic [1:0]  op;
    logic [15:0] cnt;
    logic [31:0] arg;
  } cmd_t;

  localparam int unsigned CMD_W = $bits(cmd_t);

endpackage

// File: rtl/gpio_seq_fifo.sv
// Show-ahead synchronous FIFO holding queued sequencer commands.
module gpio_seq_fifo #(
  parameter int unsigned WIDTH = 50,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout_c,
  output logic                     full_c,
  output logic                     empty_c,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push_c;
  logic             do_pop_c;

  assign full_c    = (count == CW'(DEPTH));
  assign empty_c   = (count == '0);
  assign do_push_c = push & ~full_c;
  assign do_pop_c  = pop & ~empty_c;
  assign dout_c    = mem[rptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push_c) wptr <= wptr + AW'(1);
      if (do_pop_c)  rptr <= rptr + AW'(1);
      count <= count + CW'(do_push_c) - CW'(do_pop_c);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push_c) mem[wptr] <= din;
  end

endmodule

// File: rtl/gpio_seq.sv
// Command-driven sequencer mastering the GPIO register port for bit-bang waveforms.
module gpio_seq
  import gpio_seq_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  waddr_i,
  input  logic [31:0] data_i,
  input  logic [3:0]  sel_i,
  input  logic        we_i,
  input  logic [7:0]  raddr_i,
  input  logic        rd_i,
  output logic [31:0] data_o,
  output logic [7:0]  gpio_waddr_o,
  output logic [31:0] gpio_data_o,
  output logic [3:0]  gpio_sel_o,
  output logic        gpio_we_o,
  output logic [7:0]  gpio_raddr_o,
  output logic        gpio_rd_o,
  input  logic [31:0] gpio_data_i,
  output logic        irq_o
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  state_t           state, state_n;
  logic [CNT_W-1:0] ctr, ctr_n;
  logic             tmo_en, tmo_en_n;
  logic [31:0]      poll_arg, poll_arg_n;

  logic [31:0] arg_reg, mask_reg;
  logic        ie_done, ie_err, done, timeout, overflow;

  logic ctrl_wr_c, stat_wr_c, start_c, abort_c, push_c;
  logic pop_c, flush_c, done_set_c, tmo_set_c;
  logic full_c, empty_c;
  logic [CW-1:0] fifo_count;
  logic [CMD_W-1:0] head_raw_c;
  cmd_t head_c, push_cmd_c;
  logic [31:0] rdata_c;
  logic unused_sel_c;

  assign unused_sel_c = ^sel_i;

  assign ctrl_wr_c = we_i && (waddr_i == SEQ_CTRL);
  assign stat_wr_c = we_i && (waddr_i == SEQ_STAT);
  assign start_c   = ctrl_wr_c & data_i[0];
  assign abort_c   = ctrl_wr_c & data_i[1];
  assign push_c    = we_i && (waddr_i == SEQ_CMD) && !abort_c;
  assign head_c    = cmd_t'(head_raw_c);

  always_comb begin
    push_cmd_c     = '0;
    push_cmd_c.op  = data_i[17:16];
    push_cmd_c.cnt = data_i[15:0];
    push_cmd_c.arg = arg_reg;
  end

  gpio_seq_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush_c),
    .push    (push_c),
    .din     (push_cmd_c),
    .pop     (pop_c),
    .dout_c  (head_raw_c),
    .full_c  (full_c),
    .empty_c (empty_c),
    .count   (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      ctr      <= '0;
      tmo_en   <= 1'b0;
      poll_arg <= '0;
    end else begin
      state    <= state_n;
      ctr      <= ctr_n;
      tmo_en   <= tmo_en_n;
      poll_arg <= poll_arg_n;
    end
  end

  // A DELAY of cnt spans cnt cycles from its own fetch to the next fetch.
  always_comb begin
    state_n    = state;
    ctr_n      = ctr;
    tmo_en_n   = tmo_en;
    poll_arg_n = poll_arg;
    pop_c      = 1'b0;
    flush_c    = 1'b0;
    done_set_c = 1'b0;
    tmo_set_c  = 1'b0;
    if (abort_c) begin
      flush_c = 1'b1;
      state_n = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_c) begin
            if (empty_c) done_set_c = 1'b1;
            else         state_n    = ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (empty_c) begin
            done_set_c = 1'b1;
            state_n    = ST_IDLE;
          end else begin
            pop_c      = 1'b1;
            ctr_n      = CNT_W'(head_c.cnt);
            tmo_en_n   = (head_c.cnt != 16'd0);
            poll_arg_n = head_c.arg;
            case (head_c.op)
              OP_WR_OPT, OP_WR_OEC: state_n = ST_WRITE;
              OP_DELAY: begin
                ctr_n   = CNT_W'(head_c.cnt) - CNT_W'(1);
                state_n = (head_c.cnt > 16'd1) ? ST_DELAY : ST_FETCH;
              end
              default: state_n = ST_POLL_RD;
            endcase
          end
        end
        ST_WRITE: state_n = ST_FETCH;
        ST_DELAY: begin
          if (ctr == CNT_W'(1)) state_n = ST_FETCH;
          else                  ctr_n   = ctr - CNT_W'(1);
        end
        ST_POLL_RD: state_n = ST_POLL_CHK;
        ST_POLL_CHK: begin
          if (((gpio_data_i ^ poll_arg) & mask_reg) == 32'h0) begin
            state_n = ST_FETCH;
          end else if (tmo_en && (ctr == CNT_W'(1))) begin
            tmo_set_c = 1'b1;
            flush_c   = 1'b1;
            state_n   = ST_IDLE;
          end else begin
            ctr_n   = ctr - CNT_W'(1);
            state_n = ST_POLL_RD;
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  // Slave-side registers; set events win over W1C clears.
  always_ff @(posedge clk) begin
    if (rst) begin
      arg_reg  <= '0;
      mask_reg <= '0;
      ie_done  <= 1'b0;
      ie_err   <= 1'b0;
      done     <= 1'b0;
      timeout  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (we_i && (waddr_i == SEQ_ARG))  arg_reg  <= data_i;
      if (we_i && (waddr_i == SEQ_MASK)) mask_reg <= data_i;
      if (ctrl_wr_c) begin
        ie_done <= data_i[4];
        ie_err  <= data_i[5];
      end
      done     <= done_set_c | (done & ~(stat_wr_c & data_i[1]));
      timeout  <= tmo_set_c | (timeout & ~(stat_wr_c & data_i[2]));
      overflow <= (push_c & full_c) | (overflow & ~(stat_wr_c & data_i[3]));
    end
  end

  always_comb begin
    rdata_c = 32'h0;
    case (raddr_i)
      SEQ_CTRL: rdata_c = {26'h0, ie_err, ie_done, 4'h0};
      SEQ_STAT: rdata_c = {16'h0, 8'(fifo_count), 4'h0, overflow, timeout, done,
                           (state != ST_IDLE)};
      SEQ_ARG:  rdata_c = arg_reg;
      SEQ_MASK: rdata_c = mask_reg;
      default:  rdata_c = 32'h0;
    endcase
  end

  // Strobes follow the next state so they line up with WRITE/POLL_RD.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_o       <= '0;
      gpio_waddr_o <= '0;
      gpio_data_o  <= '0;
      gpio_sel_o   <= 4'hf;
      gpio_we_o    <= 1'b0;
      gpio_raddr_o <= '0;
      gpio_rd_o    <= 1'b0;
      irq_o        <= 1'b0;
    end else begin
      if (rd_i) data_o <= rdata_c;
      gpio_sel_o   <= 4'hf;
      gpio_raddr_o <= GPIO_DIN;
      gpio_we_o    <= (state_n == ST_WRITE);
      gpio_rd_o    <= (state_n == ST_POLL_RD);
      if (state_n == ST_WRITE) begin
        gpio_waddr_o <= (head_c.op == OP_WR_OPT) ? GPIO_OPT : GPIO_OEC;
        gpio_data_o  <= head_c.arg;
      end
      irq_o <= (done & ie_done) | ((timeout | overflow) & ie_err);
    end
  end

endmodule
